// File: rtl/hvmux_spi_rx.sv
// Receive-side decoder for the HV mux serial lines (le_n / clk / din).
// Oversamples the SPI pins and presents each latched switch word as a parallel word.
module hvmux_spi_rx #(
  parameter int SWITCH_N    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spi_le_n,
  input  logic                spi_clk,
  input  logic                spi_din,
  output logic [SWITCH_N-1:0] dout,
  output logic                dvalid,
  output logic                bit_err,
  output logic                busy,
  output logic [7:0]          frame_cnt,
  output logic [7:0]          err_cnt
);
  localparam int CW = $clog2(SWITCH_N + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(SWITCH_N);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SWITCH_N + 1);

  logic [SYNC_STAGES-1:0] le_sync_q, clk_sync_q, din_sync_q;
  logic                   le_prev_q, clk_prev_q;
  logic                   le_s, clk_s, din_s;
  logic                   clk_rise, le_fall, err_d;
  logic [SWITCH_N-1:0]    shift_q, shift_d, dout_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dvalid_q, bit_err_q, busy_q;
  logic [7:0]             frame_q, err_q;

  // Reset values keep le_n idle high and clk idle low so release shows no edge
  always_ff @(posedge clk) begin
    if (rst) begin
      le_sync_q  <= '1;
      clk_sync_q <= '0;
      din_sync_q <= '0;
      le_prev_q  <= 1'b1;
      clk_prev_q <= 1'b0;
    end else begin
      le_sync_q  <= {le_sync_q[SYNC_STAGES-2:0], spi_le_n};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], spi_din};
      le_prev_q  <= le_s;
      clk_prev_q <= clk_s;
    end
  end

  assign le_s  = le_sync_q[SYNC_STAGES-1];
  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign din_s = din_sync_q[SYNC_STAGES-1];

  // Shift is resolved before the latch so a coincident clock rise lands in dout
  always_comb begin
    clk_rise = clk_s & ~clk_prev_q;
    le_fall  = le_prev_q & ~le_s;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    if (clk_rise) begin
      shift_d = {shift_q[SWITCH_N-2:0], din_s};
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
    err_d = (cnt_d != CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      dout_q    <= '0;
      cnt_q     <= '0;
      dvalid_q  <= 1'b0;
      bit_err_q <= 1'b0;
      busy_q    <= 1'b0;
      frame_q   <= '0;
      err_q     <= '0;
    end else begin
      dvalid_q <= 1'b0;
      shift_q  <= shift_d;
      if (le_fall) begin
        dout_q    <= shift_d;
        dvalid_q  <= 1'b1;
        bit_err_q <= err_d;
        frame_q   <= frame_q + 8'd1;
        if (err_d && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
        cnt_q     <= '0;
        busy_q    <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (clk_rise) busy_q <= 1'b1;
      end
    end
  end

  assign dout      = dout_q;
  assign dvalid    = dvalid_q;
  assign bit_err   = bit_err_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_q;
  assign err_cnt   = err_q;
endmodule

// File: tb/tb_hvmux_spi_rx.sv
// Bench for hvmux_spi_rx: drives SPI frames at 4 clk per phase and checks against a bit-history model.
module tb_hvmux_spi_rx;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         spi_le_n = 1'b1;
  logic         spi_clk = 1'b0;
  logic         spi_din = 1'b0;
  logic [N-1:0] dout;
  logic         dvalid, bit_err, busy;
  logic [7:0]   frame_cnt, err_cnt;

  hvmux_spi_rx #(.SWITCH_N(N), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_le_n(spi_le_n), .spi_clk(spi_clk), .spi_din(spi_din),
    .dout(dout), .dvalid(dvalid), .bit_err(bit_err), .busy(busy),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: every bit ever shifted since reset, plus counts since the last latch
  bit hist[$];
  int m_bits, m_frames, m_errs;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < N; i++) hist.push_back(1'b0);
    m_bits = 0; m_frames = 0; m_errs = 0;
  endtask

  function automatic logic [N-1:0] model_word();
    logic [N-1:0] w;
    for (int i = 0; i < N; i++) w[i] = hist[hist.size()-1-i];
    return w;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    spi_din = b;
    wait_cyc(4);
    spi_clk = 1'b1;
    hist.push_back(b);
    m_bits++;
    wait_cyc(4);
    spi_clk = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic check_busy(input string name);
    logic exp;
    wait_cyc(3);
    exp = (m_bits > 0);
    total++;
    if (busy !== exp) begin
      bad++;
      $display("FAIL %s busy got=%b exp=%b", name, busy, exp);
    end
  endtask

  // Falls le_n (optionally with a coincident clock rise) and checks the single dvalid pulse
  task automatic do_latch(input string name, input bit simul, input bit b, input bit keep_low);
    logic [N-1:0] exp_w, got_w;
    logic         exp_e, got_e, prev;
    int           pulses;
    bit           consec;
    if (simul) begin
      spi_din = b;
      wait_cyc(4);
      spi_clk = 1'b1;
      hist.push_back(b);
      m_bits++;
    end
    spi_le_n = 1'b0;
    exp_w = model_word();
    exp_e = (m_bits != N);
    m_bits = 0;
    m_frames = (m_frames + 1) % 256;
    if (exp_e && m_errs < 255) m_errs++;
    pulses = 0; consec = 0; prev = 1'b0; got_w = 'x; got_e = 1'bx;
    for (int i = 0; i < 12; i++) begin
      wait_cyc(1);
      if (dvalid === 1'b1) begin
        pulses++;
        got_w = dout;
        got_e = bit_err;
        if (prev) consec = 1;
      end
      prev = dvalid;
      if (i == 4) spi_clk = 1'b0;
      if (i == 7 && !keep_low) spi_le_n = 1'b1;
    end
    total++;
    if (pulses != 1 || consec) begin
      bad++;
      $display("FAIL %s dvalid_pulses got=%0d exp=1 consecutive=%0d", name, pulses, consec);
    end
    total++;
    if (got_w !== exp_w) begin
      bad++;
      $display("FAIL %s dout got=%h exp=%h", name, got_w, exp_w);
    end
    total++;
    if (got_e !== exp_e) begin
      bad++;
      $display("FAIL %s bit_err got=%b exp=%b", name, got_e, exp_e);
    end
    total++;
    if (frame_cnt !== 8'(m_frames) || err_cnt !== 8'(m_errs)) begin
      bad++;
      $display("FAIL %s counters got=%0d/%0d exp=%0d/%0d", name, frame_cnt, err_cnt, m_frames, m_errs);
    end
    total++;
    if (busy !== 1'b0 || dout !== exp_w) begin
      bad++;
      $display("FAIL %s after_latch busy=%b dout=%h exp busy=0 dout=%h", name, busy, dout, exp_w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(4);
    total++;
    if (dout !== '0 || dvalid !== 1'b0 || bit_err !== 1'b0 || busy !== 1'b0 ||
        frame_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset outputs got dout=%h dv=%b err=%b busy=%b fc=%0d ec=%0d exp all zero",
               dout, dvalid, bit_err, busy, frame_cnt, err_cnt);
    end
    rst = 1'b0;
    model_reset();
    wait_cyc(4);
    total++;
    if (dvalid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release dvalid=%b busy=%b exp 0 0", dvalid, busy);
    end
  endtask

  task automatic test_full_frame();
    send_word(32'hFFFF, N);
    check_busy("full_busy");
    do_latch("full", 0, 0, 0);
  endtask

  task automatic test_patterns();
    send_word(32'h5555, N);
    do_latch("pat5555", 0, 0, 0);
    send_word(32'hAAAA, N);
    do_latch("patAAAA", 0, 0, 0);
  endtask

  task automatic test_short_frame();
    send_word(32'h0000, N);
    do_latch("zero", 0, 0, 0);
    send_word(32'hA5, 8);
    check_busy("short_busy");
    do_latch("short", 0, 0, 0);
  endtask

  task automatic test_long_frame();
    send_word(32'h11234, 17);
    do_latch("long", 0, 0, 0);
  endtask

  task automatic test_relatch();
    do_latch("relatch", 0, 0, 0);
  endtask

  task automatic test_simultaneous();
    send_word(32'h3C5A >> 1, N - 1);
    do_latch("simul_ok", 1, 0, 0);
    send_word(32'h00F1, N);
    do_latch("simul_long", 1, 1, 0);
  endtask

  task automatic test_clock_le_low();
    send_word(32'h8001, N);
    do_latch("le_low_a", 0, 0, 1);
    send_word(32'h7E3D, N);
    spi_le_n = 1'b1;
    wait_cyc(4);
    do_latch("le_low_b", 0, 0, 0);
  endtask

  task automatic test_random();
    int n;
    logic [31:0] w;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(0, 20);
      w = $urandom;
      send_word(w, n);
      check_busy("rand_busy");
      do_latch("rand", ($urandom_range(0, 3) == 0), w[20], 0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int dv_seen;
    send_word(32'h15, 5);
    check_busy("mid_busy");
    rst = 1'b1;
    dv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(1);
      if (dvalid !== 1'b0) dv_seen++;
    end
    total++;
    if (dv_seen != 0 || dout !== '0 || busy !== 1'b0 || frame_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL mid_reset dv_seen=%0d dout=%h busy=%b fc=%0d ec=%0d exp 0", dv_seen, dout, busy, frame_cnt, err_cnt);
    end
    rst = 1'b0;
    model_reset();
    wait_cyc(3);
    send_word(32'hC3C3, N);
    do_latch("after_reset", 0, 0, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_frame();
    test_patterns();
    test_short_frame();
    test_long_frame();
    test_relatch();
    test_simultaneous();
    test_clock_le_low();
    test_random();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
